force_wb_collector: RTL



---
 rtl/force_wb_collector.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/force_wb_collector.sv
// Buffers per-accumulator force results in small FIFOs and serializes them
// round-robin into one registered ready/valid write-back stream.
module force_wb_collector #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned PARTICLE_ID_WIDTH = 20,
    parameter int unsigned CELL_ID_WIDTH     = 3,
    parameter int unsigned ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
    parameter int unsigned NUM_ACC           = 7,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ACC-1:0]             in_acc_valid,
    input  logic [NUM_ACC*ID_WIDTH-1:0]    in_acc_id,
    input  logic [NUM_ACC*DATA_WIDTH-1:0]  in_acc_force_x,
    input  logic [NUM_ACC*DATA_WIDTH-1:0]  in_acc_force_y,
    input  logic [NUM_ACC*DATA_WIDTH-1:0]  in_acc_force_z,
    input  logic                           in_clear_overflow,
    input  logic                           in_wb_ready,
    output logic                           out_wb_valid,
    output logic [ID_WIDTH-1:0]            out_wb_id,
    output logic [DATA_WIDTH-1:0]          out_wb_force_x,
    output logic [DATA_WIDTH-1:0]          out_wb_force_y,
    output logic [DATA_WIDTH-1:0]          out_wb_force_z,
    output logic [2:0]                     out_wb_src,
    output logic [NUM_ACC-1:0]             out_overflow,
    output logic [CNT_WIDTH-1:0]           out_wb_count,
    output logic                           out_idle
);

    localparam int unsigned ENTRY_W = ID_WIDTH + 3*DATA_WIDTH;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned SRC_W   = 3;

    logic [ENTRY_W-1:0] mem       [NUM_ACC][FIFO_DEPTH];
    logic [ENTRY_W-1:0] push_data [NUM_ACC];
    logic [PTR_W-1:0]   wr_ptr    [NUM_ACC];
    logic [PTR_W-1:0]   rd_ptr    [NUM_ACC];
    logic [FCNT_W-1:0]  fifo_cnt  [NUM_ACC];
    logic [FCNT_W-1:0]  cnt_nxt   [NUM_ACC];

    logic [NUM_ACC-1:0] nonempty;
    logic [NUM_ACC-1:0] push;
    logic [NUM_ACC-1:0] pop;
    logic [NUM_ACC-1:0] drop;
    logic [SRC_W-1:0]   arb_ptr;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   scan_idx;
    logic [ENTRY_W-1:0] head_data;
    logic               any_head;
    logic               load;
    logic               valid_nxt;
    logic               all_empty_nxt;

    // Unpack channel inputs into FIFO entries, id in the MSBs.
    always_comb begin
        for (int k = 0; k < int'(NUM_ACC); k++) begin
            push_data[k] = {in_acc_id[k*ID_WIDTH +: ID_WIDTH],
                            in_acc_force_x[k*DATA_WIDTH +: DATA_WIDTH],
                            in_acc_force_y[k*DATA_WIDTH +: DATA_WIDTH],
                            in_acc_force_z[k*DATA_WIDTH +: DATA_WIDTH]};
            nonempty[k]  = (fifo_cnt[k] != '0);
        end
    end

    // Round-robin search starting one past the last grant.
    always_comb begin
        grant    = '0;
        any_head = 1'b0;
        scan_idx = '0;
        for (int i = 1; i <= int'(NUM_ACC); i++) begin
            scan_idx = SRC_W'((int'(arb_ptr) + i) % int'(NUM_ACC));
            if (!any_head && nonempty[scan_idx]) begin
                grant    = scan_idx;
                any_head = 1'b1;
            end
        end
    end

    assign load      = !out_wb_valid || in_wb_ready;
    assign valid_nxt = load ? any_head : out_wb_valid;
    assign head_data = mem[grant][rd_ptr[grant]];
    assign pop       = (load && any_head) ? (NUM_ACC'(1) << grant) : '0;

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    always_comb begin
        push          = '0;
        drop          = '0;
        all_empty_nxt = 1'b1;
        for (int k = 0; k < int'(NUM_ACC); k++) begin
            push[k] = in_acc_valid[k] && ((fifo_cnt[k] != FCNT_W'(FIFO_DEPTH)) || pop[k]);
            drop[k] = in_acc_valid[k] && (fifo_cnt[k] == FCNT_W'(FIFO_DEPTH)) && !pop[k];
            case ({push[k], pop[k]})
                2'b10:   cnt_nxt[k] = fifo_cnt[k] + FCNT_W'(1);
                2'b01:   cnt_nxt[k] = fifo_cnt[k] - FCNT_W'(1);
                default: cnt_nxt[k] = fifo_cnt[k];
            endcase
            if (cnt_nxt[k] != '0) begin
                all_empty_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NUM_ACC); k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= push_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(NUM_ACC); k++) begin
                wr_ptr[k]   <= '0;
                rd_ptr[k]   <= '0;
                fifo_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_ACC); k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                fifo_cnt[k] <= cnt_nxt[k];
            end
        end
    end

    // Output register, arbiter pointer, status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wb_valid   <= 1'b0;
            out_wb_id      <= '0;
            out_wb_force_x <= '0;
            out_wb_force_y <= '0;
            out_wb_force_z <= '0;
            out_wb_src     <= '0;
            arb_ptr        <= SRC_W'(NUM_ACC - 1);
            out_overflow   <= '0;
            out_wb_count   <= '0;
            out_idle       <= 1'b1;
        end else begin
            if (load) begin
                out_wb_valid <= any_head;
                if (any_head) begin
                    {out_wb_id, out_wb_force_x, out_wb_force_y, out_wb_force_z} <= head_data;
                    out_wb_src <= grant;
                    arb_ptr    <= grant;
                end
            end
            if (out_wb_valid && in_wb_ready) begin
                out_wb_count <= out_wb_count + CNT_WIDTH'(1);
            end
            out_overflow <= drop | (in_clear_overflow ? '0 : out_overflow);
            out_idle     <= all_empty_nxt && !valid_nxt;
        end
    end

endmodule
